// File: rtl/alu_pkg.sv
// Shared types for the EX-stage ALU: decoded op codes, aluop classes, funct7 fields, FSM states.
package alu_pkg;

    typedef enum logic [4:0] {
        OpAdd, OpSub, OpSll, OpSlt, OpSltu, OpXor, OpSrl, OpSra, OpOr, OpAnd,
        OpMul, OpMulh, OpMulhsu, OpMulhu, OpDiv, OpDivu, OpRem, OpRemu,
        OpIllegal
    } alu_op_e;

    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

    localparam int unsigned F7_ALT_BIT = 5;
    localparam int unsigned F7_M_BIT   = 0;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} exec_state_e;

    function automatic logic is_muldiv(alu_op_e op);
        return op inside {OpMul, OpMulh, OpMulhsu, OpMulhu, OpDiv, OpDivu, OpRem, OpRemu};
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative RV-M core: shift-add multiply and restoring divide on magnitudes, signs fixed on the
// final step. start_i loads operands; done_o pulses with result_o valid in the last step cycle.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int unsigned XLEN             = 32,
    parameter int unsigned MUL_BITS_PER_CYC = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  alu_op_e         op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int unsigned     CntW    = $clog2(XLEN);
    localparam logic [CntW-1:0] MulLast = CntW'(XLEN / MUL_BITS_PER_CYC - 1);
    localparam logic [CntW-1:0] DivLast = CntW'(XLEN - 1);

    logic                run_q;
    alu_op_e             op_q;
    logic [CntW-1:0]     cnt_q;
    logic                neg_q;
    logic                bzero_q;
    logic [XLEN-1:0]     aorig_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [2*XLEN-1:0]   mcand_q;
    logic [XLEN-1:0]     shreg_q;   // multiplier bits (mul) or dividend/quotient (div)
    logic [XLEN-1:0]     dvsr_q;
    logic [XLEN-1:0]     rem_q;

    logic                start_div, a_sgn, b_sgn, start_neg;
    logic [XLEN-1:0]     a_mag, b_mag;

    always_comb begin
        start_div = op_i inside {OpDiv, OpDivu, OpRem, OpRemu};
        a_sgn     = (op_i inside {OpMulh, OpMulhsu, OpDiv, OpRem}) && a_i[XLEN-1];
        b_sgn     = (op_i inside {OpMulh, OpDiv, OpRem}) && b_i[XLEN-1];
        a_mag     = a_sgn ? -a_i : a_i;
        b_mag     = b_sgn ? -b_i : b_i;
        // Remainder takes the dividend's sign; products and quotients the xor of both
        start_neg = (op_i == OpRem) ? a_sgn : (a_sgn ^ b_sgn);
    end

    logic                is_div_q, ge;
    logic [2*XLEN-1:0]   acc_n, prod_s;
    logic [XLEN:0]       trial;
    logic [XLEN-1:0]     diff, rem_n, quo_n, quo_s, rem_s;

    always_comb begin
        acc_n = acc_q;
        for (int unsigned i = 0; i < MUL_BITS_PER_CYC; i++) begin
            if (shreg_q[i]) acc_n = acc_n + (mcand_q << i);
        end
        trial  = {rem_q, shreg_q[XLEN-1]};
        ge     = trial >= {1'b0, dvsr_q};
        diff   = trial[XLEN-1:0] - dvsr_q;
        rem_n  = ge ? diff : trial[XLEN-1:0];
        quo_n  = {shreg_q[XLEN-2:0], ge};
        prod_s = neg_q ? -acc_n : acc_n;
        quo_s  = neg_q ? -quo_n : quo_n;
        rem_s  = neg_q ? -rem_n : rem_n;

        is_div_q = op_q inside {OpDiv, OpDivu, OpRem, OpRemu};
        done_o   = run_q && (cnt_q == (is_div_q ? DivLast : MulLast));

        unique case (op_q)
            OpMulh, OpMulhsu, OpMulhu: result_o = prod_s[2*XLEN-1:XLEN];
            OpDiv, OpDivu:             result_o = bzero_q ? '1 : quo_s;
            OpRem, OpRemu:             result_o = bzero_q ? aorig_q : rem_s;
            default:                   result_o = prod_s[XLEN-1:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q   <= 1'b0;
            op_q    <= OpAdd;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            bzero_q <= 1'b0;
            aorig_q <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            shreg_q <= '0;
            dvsr_q  <= '0;
            rem_q   <= '0;
        end else if (start_i) begin
            run_q   <= 1'b1;
            op_q    <= op_i;
            cnt_q   <= '0;
            neg_q   <= start_neg;
            bzero_q <= (b_i == '0);
            aorig_q <= a_i;
            acc_q   <= '0;
            mcand_q <= {{XLEN{1'b0}}, a_mag};
            shreg_q <= start_div ? a_mag : b_mag;
            dvsr_q  <= b_mag;
            rem_q   <= '0;
        end else if (run_q) begin
            cnt_q <= cnt_q + CntW'(1);
            if (done_o) run_q <= 1'b0;
            if (is_div_q) begin
                rem_q   <= rem_n;
                shreg_q <= quo_n;
            end else begin
                acc_q   <= acc_n;
                mcand_q <= mcand_q << MUL_BITS_PER_CYC;
                shreg_q <= shreg_q >> MUL_BITS_PER_CYC;
            end
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage ALU with valid/ready handshakes and a registered result. Optional iterative RV-M
// MUL/DIV is built only when ALU_EXEC_MULDIV_EN is defined; otherwise M ops decode as illegal.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int unsigned XLEN             = 32,
    parameter int unsigned MUL_BITS_PER_CYC = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      aluop,
    input  logic [6:0]      funct7,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal,
    output logic            busy
);

    localparam int unsigned ShW    = $clog2(XLEN);
    localparam logic [6:0]  F7Base = 7'd0;
    localparam logic [6:0]  F7Alt  = 7'(1 << F7_ALT_BIT);
    localparam logic [6:0]  F7M    = 7'(1 << F7_M_BIT);

    if ((XLEN & (XLEN - 1)) != 0 || XLEN < 8 || (XLEN % MUL_BITS_PER_CYC) != 0 ||
        !(MUL_BITS_PER_CYC == 1 || MUL_BITS_PER_CYC == 2 || MUL_BITS_PER_CYC == 4))
    begin : g_bad_cfg
        $error("alu_exec_unit: unsupported XLEN / MUL_BITS_PER_CYC");
    end

    exec_state_e     state_q;
    logic            out_valid_q, zero_q, illegal_q;
    logic [XLEN-1:0] result_q;

    alu_op_e         dec_op;
    logic [ShW-1:0]  shamt;
    logic [XLEN-1:0] alu_res;
    logic            accept, start_m;
    logic            md_done;
    logic [XLEN-1:0] md_result;

    always_comb begin
        dec_op = OpIllegal;
        if (aluop == ALUOP_MEM) begin
            dec_op = OpAdd;
        end else if (aluop == ALUOP_BRANCH) begin
            dec_op = OpSub;
        end else if (aluop == ALUOP_RTYPE && funct7 == F7M) begin
`ifdef ALU_EXEC_MULDIV_EN
            unique case (funct3)
                3'b000:  dec_op = OpMul;
                3'b001:  dec_op = OpMulh;
                3'b010:  dec_op = OpMulhsu;
                3'b011:  dec_op = OpMulhu;
                3'b100:  dec_op = OpDiv;
                3'b101:  dec_op = OpDivu;
                3'b110:  dec_op = OpRem;
                default: dec_op = OpRemu;
            endcase
`endif
        end else if (aluop == ALUOP_RTYPE && funct7 != F7Base && funct7 != F7Alt) begin
            dec_op = OpIllegal;
        end else begin
            // I-type immediates carry arbitrary upper bits; only SRAI looks at the alt bit
            unique case (funct3)
                3'b000:  dec_op = (aluop == ALUOP_RTYPE && funct7[F7_ALT_BIT]) ? OpSub : OpAdd;
                3'b001:  dec_op = OpSll;
                3'b010:  dec_op = OpSlt;
                3'b011:  dec_op = OpSltu;
                3'b100:  dec_op = OpXor;
                3'b101:  dec_op = funct7[F7_ALT_BIT] ? OpSra : OpSrl;
                3'b110:  dec_op = OpOr;
                default: dec_op = OpAnd;
            endcase
        end
    end

    always_comb begin
        shamt = op_b[ShW-1:0];
        unique case (dec_op)
            OpAdd:   alu_res = op_a + op_b;
            OpSub:   alu_res = op_a - op_b;
            OpSll:   alu_res = op_a << shamt;
            OpSlt:   alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            OpSltu:  alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            OpXor:   alu_res = op_a ^ op_b;
            OpSrl:   alu_res = op_a >> shamt;
            OpSra:   alu_res = XLEN'($signed(op_a) >>> shamt);
            OpOr:    alu_res = op_a | op_b;
            OpAnd:   alu_res = op_a & op_b;
            default: alu_res = '0;
        endcase
    end

    assign in_ready = (state_q == StIdle) || (state_q == StDone && out_ready);
    assign accept   = in_valid && in_ready;
    assign start_m  = accept && is_muldiv(dec_op);

`ifdef ALU_EXEC_MULDIV_EN
    alu_muldiv_iter #(
        .XLEN             (XLEN),
        .MUL_BITS_PER_CYC (MUL_BITS_PER_CYC)
    ) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_m),
        .op_i     (dec_op),
        .a_i      (op_a),
        .b_i      (op_b),
        .done_o   (md_done),
        .result_o (md_result)
    );
    assign busy = (state_q == StCalc);
`else
    assign md_done   = 1'b0;
    assign md_result = '0;
    assign busy      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (state_q == StDone && out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                    if (accept) begin
                        if (start_m) begin
                            out_valid_q <= 1'b0;
                            state_q     <= StCalc;
                        end else begin
                            out_valid_q <= 1'b1;
                            state_q     <= StDone;
                            result_q    <= alu_res;
                            zero_q      <= (alu_res == '0);
                            illegal_q   <= (dec_op == OpIllegal);
                        end
                    end
                end
                StCalc: begin
                    if (md_done) begin
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                        result_q    <= md_result;
                        zero_q      <= (md_result == '0);
                        illegal_q   <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed corner cases plus random ops against a
// behavioural model. Define ALU_EXEC_MULDIV_EN to cover the iterative M ops.
module tb_alu_exec_unit;

    localparam int unsigned XLEN = 32;
`ifdef ALU_EXEC_MULDIV_EN
    localparam bit MdEn = 1'b1;
`else
    localparam bit MdEn = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b1;
    logic [1:0]      aluop = 2'b00;
    logic [6:0]      funct7 = 7'd0;
    logic [2:0]      funct3 = 3'd0;
    logic [XLEN-1:0] op_a = '0;
    logic [XLEN-1:0] op_b = '0;
    logic            in_ready, out_valid, zero, illegal, busy;
    logic [XLEN-1:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(
        .XLEN             (XLEN),
        .MUL_BITS_PER_CYC (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .aluop     (aluop),
        .funct7    (funct7),
        .funct3    (funct3),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal),
        .busy      (busy)
    );

    // Reference: RISC-V semantics in 64-bit integer arithmetic
    function automatic void model(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ill, output int lat);
        longint          sa, sb, p;
        longint unsigned ua, ub, pu;
        int unsigned     sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        sh = int'(b[4:0]);
        r = '0; ill = 1'b0; lat = 1;
        if (op == 2'b00) begin
            r = a + b;
        end else if (op == 2'b01) begin
            r = a - b;
        end else if (op == 2'b10 && f7 == 7'h01) begin
            if (!MdEn) begin
                ill = 1'b1;
            end else begin
                lat = XLEN + 1;
                case (f3)
                    3'd0: begin p = sa * sb;           r = p[31:0];   end
                    3'd1: begin p = sa * sb;           r = p[63:32];  end
                    3'd2: begin p = sa * longint'(ua); r = p[63:32];  end
                    3'd3: begin pu = ua * ub;          r = pu[63:32]; end
                    3'd4: begin
                        if (b == 0) r = 32'hFFFF_FFFF;
                        else begin p = sa / sb; r = p[31:0]; end
                    end
                    3'd5: begin
                        if (b == 0) r = 32'hFFFF_FFFF;
                        else begin pu = ua / ub; r = pu[31:0]; end
                    end
                    3'd6: begin
                        if (b == 0) r = a;
                        else begin p = sa % sb; r = p[31:0]; end
                    end
                    default: begin
                        if (b == 0) r = a;
                        else begin pu = ua % ub; r = pu[31:0]; end
                    end
                endcase
            end
        end else if (op == 2'b10 && f7 != 7'h00 && f7 != 7'h20) begin
            ill = 1'b1;
        end else begin
            case (f3)
                3'd0: r = (op == 2'b10 && f7[5]) ? a - b : a + b;
                3'd1: begin pu = ua * (64'd1 << sh); r = pu[31:0]; end
                3'd2: r = (sa < sb) ? 32'd1 : 32'd0;
                3'd3: r = (ua < ub) ? 32'd1 : 32'd0;
                3'd4: r = a ^ b;
                3'd5: begin
                    pu = ua / (64'd1 << sh);
                    r  = pu[31:0];
                    if (f7[5] && a[31]) r = ~((~a) >> sh);
                end
                3'd6: r = a | b;
                default: r = a & b;
            endcase
        end
    endfunction

    // Present one op, wait for its result (bounded), consume it; returns at 1 time unit past an edge
    task automatic run_op(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic z, output logic ill,
                          output int lat, output int busy_cnt);
        int guard;
        aluop = op; funct3 = f3; funct7 = f7; op_a = a; op_b = b;
        in_valid = 1'b1; out_ready = 1'b1;
        lat = 0; busy_cnt = 0; guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            guard++;
            @(negedge clk);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        op_a = $urandom; op_b = $urandom;
        do begin
            @(negedge clk);
            lat++;
            if (busy) busy_cnt++;
        end while (!out_valid && lat < 200);
        if (guard >= 100) lat = -1;
        r = result; z = zero; ill = illegal;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({in_ready, out_valid, zero, illegal, busy} !== 5'b10000 || result !== '0) begin
            n_fail++;
            $display("FAIL reset_state: rdy/vld/zero/ill/busy=%b result=%h, required 10000 / 0",
                     {in_ready, out_valid, zero, illegal, busy}, result);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_directed_base();
        logic [31:0] r; logic z, ill; int lat, bc;
        run_op(2'b10, 3'b000, 7'h20, 32'd5, 32'd7, r, z, ill, lat, bc);
        n_checks++;
        if (r !== 32'hFFFF_FFFE || z !== 1'b0 || ill !== 1'b0 || lat != 1) begin
            n_fail++;
            $display("FAIL sub_5_7: result=%h zero=%b ill=%b lat=%0d, required fffffffe 0 0 1",
                     r, z, ill, lat);
        end
        run_op(2'b01, 3'b101, 7'h7f, 32'h1234, 32'h1234, r, z, ill, lat, bc);
        n_checks++;
        if (r !== 32'h0 || z !== 1'b1 || ill !== 1'b0) begin
            n_fail++;
            $display("FAIL branch_eq: result=%h zero=%b ill=%b, required 0 1 0", r, z, ill);
        end
        run_op(2'b10, 3'b001, 7'h11, 32'h1, 32'h2, r, z, ill, lat, bc);
        n_checks++;
        if (r !== 32'h0 || z !== 1'b1 || ill !== 1'b1 || lat != 1) begin
            n_fail++;
            $display("FAIL rtype_bad_f7: result=%h zero=%b ill=%b lat=%0d, required 0 1 1 1",
                     r, z, ill, lat);
        end
        run_op(2'b11, 3'b101, 7'h20, 32'h8000_0010, 32'h0000_0404, r, z, ill, lat, bc);
        n_checks++;
        if (r !== 32'hF800_0001 || ill !== 1'b0) begin
            n_fail++;
            $display("FAIL srai: result=%h ill=%b, required f8000001 0", r, ill);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q[$];
        logic [31:0] r, a, b;
        logic ill;
        int lat;
        for (int i = 0; i < 8; i++) begin
            a = $urandom; b = $urandom;
            aluop = (i % 2 == 0) ? 2'b10 : 2'b11; funct3 = 3'b001;
            funct7 = (i % 2 == 0) ? 7'h00 : 7'($urandom);
            op_a = a; op_b = b; in_valid = 1'b1; out_ready = 1'b1;
            model(aluop, funct3, funct7, a, b, r, ill, lat);
            exp_q.push_back(r);
            @(negedge clk);
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_ready[%0d]: in_ready=%b, required 1", i, in_ready);
            end
            if (i > 0) begin
                r = exp_q.pop_front();
                n_checks++;
                if (out_valid !== 1'b1 || result !== r) begin
                    n_fail++;
                    $display("FAIL b2b_result[%0d]: valid=%b result=%h, required 1 %h",
                             i - 1, out_valid, result, r);
                end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        r = exp_q.pop_front();
        n_checks++;
        if (out_valid !== 1'b1 || result !== r) begin
            n_fail++;
            $display("FAIL b2b_result[7]: valid=%b result=%h, required 1 %h", out_valid, result, r);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [31:0] a, b, r, er;
        logic [1:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic z, ill, eill;
        int lat, elat, bc;
        for (int i = 0; i < 60; i++) begin
            op = 2'($urandom);
            f3 = 3'($urandom);
            case ($urandom_range(0, 3))
                0: f7 = 7'h00;
                1: f7 = 7'h20;
                2: f7 = 7'h01;
                default: f7 = 7'($urandom);
            endcase
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            model(op, f3, f7, a, b, er, eill, elat);
            run_op(op, f3, f7, a, b, r, z, ill, lat, bc);
            n_checks++;
            if (r !== er || z !== (er == 0) || ill !== eill || lat != elat) begin
                n_fail++;
                $display("FAIL random[%0d] op=%b f3=%0d f7=%h a=%h b=%h: result=%h zero=%b ill=%b lat=%0d, required %h %b %b %0d",
                         i, op, f3, f7, a, b, r, z, ill, lat, er, (er == 0), eill, elat);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] e1, e2;
        logic ill;
        int lat;
        aluop = 2'b10; funct3 = 3'b100; funct7 = 7'h00;
        op_a = $urandom; op_b = $urandom;
        model(aluop, funct3, funct7, op_a, op_b, e1, ill, lat);
        in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        aluop = 2'b11; funct3 = 3'b110; funct7 = 7'($urandom);
        op_a = $urandom; op_b = $urandom;
        model(aluop, funct3, funct7, op_a, op_b, e2, ill, lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || result !== e1 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: valid=%b result=%h in_ready=%b, required 1 %h 0",
                         i, out_valid, result, in_ready, e1);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || result !== e1) begin
            n_fail++;
            $display("FAIL stall_release: in_ready=%b result=%h, required 1 %h", in_ready, result, e1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || result !== e2) begin
            n_fail++;
            $display("FAIL stall_next: valid=%b result=%h, required 1 %h", out_valid, result, e2);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_muldiv();
        logic [31:0] r; logic z, ill; int lat, bc;
`ifdef ALU_EXEC_MULDIV_EN
        logic [31:0] va[6], vb[6], ve[6];
        logic [2:0]  vf[6];
        run_op(2'b10, 3'b001, 7'h01, 32'h8000_0000, 32'd2, r, z, ill, lat, bc);
        n_checks++;
        if (r !== 32'hFFFF_FFFF || lat != 33 || bc != 32 || ill !== 1'b0) begin
            n_fail++;
            $display("FAIL mulh_min_2: result=%h lat=%0d busy_cycles=%0d ill=%b, required ffffffff 33 32 0",
                     r, lat, bc, ill);
        end
        va = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd123, 32'h8000_0000, 32'h8000_0000, 32'd77};
        vb = '{32'd2, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
        vf = '{3'd4, 3'd6, 3'd5, 3'd4, 3'd6, 3'd6};
        ve = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32'd77};
        for (int i = 0; i < 6; i++) begin
            run_op(2'b10, vf[i], 7'h01, va[i], vb[i], r, z, ill, lat, bc);
            n_checks++;
            if (r !== ve[i] || lat != 33 || z !== (ve[i] == 0)) begin
                n_fail++;
                $display("FAIL div_case[%0d] f3=%0d a=%h b=%h: result=%h lat=%0d zero=%b, required %h 33 %b",
                         i, vf[i], va[i], vb[i], r, lat, z, ve[i], (ve[i] == 0));
            end
        end
`else
        run_op(2'b10, 3'b000, 7'h01, 32'd6, 32'd7, r, z, ill, lat, bc);
        n_checks++;
        if (ill !== 1'b1 || r !== 32'h0 || lat != 1 || bc != 0) begin
            n_fail++;
            $display("FAIL mul_disabled: ill=%b result=%h lat=%0d busy_cycles=%0d, required 1 0 1 0",
                     ill, r, lat, bc);
        end
`endif
    endtask

    task automatic test_reset_abort();
        int seen = 0;
        aluop = 2'b10; op_a = 32'hFFFF_FF00; op_b = 32'd3;
        funct3 = MdEn ? 3'b100 : 3'b100;
        funct7 = MdEn ? 7'h01 : 7'h00;
        out_ready = MdEn ? 1'b1 : 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || result !== '0) begin
            n_fail++;
            $display("FAIL reset_abort: valid=%b in_ready=%b busy=%b result=%h, required 0 1 0 0",
                     out_valid, in_ready, busy, result);
        end
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL reset_no_result: out_valid seen %0d cycles, required 0", seen);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_directed_base();
        test_back_to_back();
        test_stall();
        test_muldiv();
        test_random();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
